// File: rtl/chrono_pkg.sv
// Shared definitions for the stopwatch controller: state encodings, display width,
// wrap time and default clock rates.
package chrono_pkg;

  localparam int BCD_W = 24;
  localparam logic [BCD_W-1:0] MAX_TIME = 24'h595999;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_TICK_HZ = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  function automatic logic is_running(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/chrono_if.sv
// Signal bundle between the stopwatch controller (master) and the button /
// BCD counter / display side (slave).
interface chrono_if;
  import chrono_pkg::*;

  // Handshake: there is no valid/ready pair. Each *_btn is a one-cycle strobe
  // consumed on the rising edge that samples it; tick_en and cnt_clr are
  // one-cycle strobes to the counter; time_bcd, disp_bcd, running and state
  // are level signals valid every cycle.
  logic             start_btn;
  logic             lap_btn;
  logic             clr_btn;
  logic [BCD_W-1:0] time_bcd;
  logic             tick_en;
  logic             cnt_clr;
  logic [BCD_W-1:0] disp_bcd;
  logic             running;
  state_t           state;

  modport master (
    input  start_btn, lap_btn, clr_btn, time_bcd,
    output tick_en, cnt_clr, disp_bcd, running, state
  );

  modport slave (
    output start_btn, lap_btn, clr_btn, time_bcd,
    input  tick_en, cnt_clr, disp_bcd, running, state
  );

endinterface

// File: rtl/chrono_prescaler.sv
// Divides the system clock down to the stopwatch tick: counts 0..DIV-1 while
// enabled, holds when disabled, and emits a one-cycle tick after each wrap.
module chrono_prescaler #(
  parameter int DIV = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // The wrap pulse is registered so it appears exactly DIV cycles after the
  // start edge; a stop on the wrap edge still delivers that final tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/chrono_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, tick prescaler and display mux.
// Define CHRONO_LAP_EN to build the LAP state and lap-time freeze register.
module chrono_ctrl
  import chrono_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ
) (
  input  logic     CLOCK_50,
  input  logic     RST,
  chrono_if.master bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  state_t state_q;
  state_t state_d;
  logic   clr_acc;
  logic   cnt_clr_q;
  logic   run_now;
`ifdef CHRONO_LAP_EN
  logic             lap_cap;
  logic [BCD_W-1:0] lap_q;
`endif

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= clr_acc;
    end
  end

  // Priority start > lap > clr; a pulse illegal in the current state does not
  // block a lower-priority legal one.
  always_comb begin
    state_d = state_q;
    clr_acc = 1'b0;
`ifdef CHRONO_LAP_EN
    lap_cap = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_btn)    state_d = ST_RUN;
        else if (bus.clr_btn) clr_acc = 1'b1;
      end
      ST_RUN: begin
        if (bus.start_btn) state_d = ST_PAUSE;
`ifdef CHRONO_LAP_EN
        else if (bus.lap_btn) begin
          state_d = ST_LAP;
          lap_cap = 1'b1;
        end
`endif
      end
      ST_PAUSE: begin
        if (bus.start_btn) state_d = ST_RUN;
        else if (bus.clr_btn) begin
          state_d = ST_IDLE;
          clr_acc = 1'b1;
        end
      end
`ifdef CHRONO_LAP_EN
      ST_LAP: begin
        if (bus.start_btn)    state_d = ST_PAUSE;
        else if (bus.lap_btn) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_now = is_running(state_q);

  chrono_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (CLOCK_50),
    .rst_n (RST),
    .en    (run_now),
    .clr   (clr_acc),
    .tick  (bus.tick_en)
  );

  assign bus.cnt_clr = cnt_clr_q;
  assign bus.running = run_now;
  assign bus.state   = state_q;

`ifdef CHRONO_LAP_EN
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST)         lap_q <= '0;
    else if (lap_cap) lap_q <= bus.time_bcd;
  end

  assign bus.disp_bcd = (state_q == ST_LAP) ? lap_q : bus.time_bcd;
`else
  assign bus.disp_bcd = bus.time_bcd;
`endif

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed bench for chrono_ctrl at DIV=10; tick and clear strobes are checked
// against expected edge numbers queued when the stimulus is planned.
module tb_chrono_ctrl;
  import chrono_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic CLOCK_50;
  logic RST;

  chrono_if bus ();

  chrono_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .bus      (bus)
  );

  // clock / edge numbering
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  logic [31:0] edge_cnt = 32'd0;
  always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 32'd1;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // scoreboard
  int          checks   = 0;
  int          failures = 0;
  int          phase    = 0;
  logic [31:0] exp_tick_q[$];
  logic [31:0] exp_clr_q[$];
  logic [31:0] exp_t;
  logic [31:0] exp_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the edges at which the prescaler wraps during a run from edge
  // from_e (start sampled) to edge to_e (stop sampled).
  task automatic push_run(input logic [31:0] from_e, input logic [31:0] to_e);
    for (logic [31:0] e = from_e + 32'd1; e <= to_e; e++) begin
      if (phase == DIV - 1) begin
        exp_tick_q.push_back(e);
        phase = 0;
      end else begin
        phase++;
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (RST) begin
      if (bus.tick_en) begin
        exp_t = (exp_tick_q.size() != 0) ? exp_tick_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        assert (edge_cnt === exp_t) else begin
          failures++;
          $error("FAIL tick_time observed_edge=%0d expected_edge=%0d", edge_cnt, exp_t);
        end
      end else if (exp_tick_q.size() != 0 && exp_tick_q[0] <= edge_cnt) begin
        exp_t = exp_tick_q.pop_front();
        checks++;
        assert (bus.tick_en === 1'b1) else begin
          failures++;
          $error("FAIL tick_missing observed=%0b expected=1 at_edge=%0d", bus.tick_en, exp_t);
        end
      end
      if (bus.cnt_clr) begin
        exp_c = (exp_clr_q.size() != 0) ? exp_clr_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        assert (edge_cnt === exp_c) else begin
          failures++;
          $error("FAIL cnt_clr_time observed_edge=%0d expected_edge=%0d", edge_cnt, exp_c);
        end
      end else if (exp_clr_q.size() != 0 && exp_clr_q[0] <= edge_cnt) begin
        exp_c = exp_clr_q.pop_front();
        checks++;
        assert (bus.cnt_clr === 1'b1) else begin
          failures++;
          $error("FAIL cnt_clr_missing observed=%0b expected=1 at_edge=%0d", bus.cnt_clr, exp_c);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_to(input logic [31:0] e);
    while (edge_cnt < e) @(negedge CLOCK_50);
  endtask

  task automatic pulse(input logic s, input logic l, input logic c, output logic [31:0] e);
    bus.start_btn = s;
    bus.lap_btn   = l;
    bus.clr_btn   = c;
    e = edge_cnt + 32'd1;
    @(negedge CLOCK_50);
    bus.start_btn = 1'b0;
    bus.lap_btn   = 1'b0;
    bus.clr_btn   = 1'b0;
  endtask

  logic [31:0] e;
  logic [31:0] s_e;
  logic [31:0] r_e;
  logic [31:0] p_e;
  logic [31:0] c_e;

  initial begin
    RST           = 1'b0;
    bus.start_btn = 1'b0;
    bus.lap_btn   = 1'b0;
    bus.clr_btn   = 1'b0;
    bus.time_bcd  = 24'h595959;
    #22;
    chk("rst_state",   32'(bus.state), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_tick",    32'(bus.tick_en), 32'd0);
    chk("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
    chk("rst_disp",    32'(bus.disp_bcd), 32'h595959);

    // start on the first edge after release, run 25, pause 50, resume
    @(negedge CLOCK_50);
    RST = 1'b1;
    bus.time_bcd = 24'h000042;
    pulse(1'b1, 1'b0, 1'b0, s_e);
    chk("start_state",   32'(bus.state), 32'd1);
    chk("start_running", 32'(bus.running), 32'd1);
    chk("run_disp_live", 32'(bus.disp_bcd), 32'h000042);
    phase = 0;
    push_run(s_e, s_e + 32'd25);

    wait_to(s_e + 32'd14);
    pulse(1'b0, 1'b0, 1'b1, e);
    chk("clr_in_run_state", 32'(bus.state), 32'd1);

    wait_to(s_e + 32'd24);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("pause_state",   32'(bus.state), 32'd2);
    chk("pause_running", 32'(bus.running), 32'd0);

    wait_to(s_e + 32'd35);
    pulse(1'b0, 1'b1, 1'b0, e);
    chk("lap_in_pause_state", 32'(bus.state), 32'd2);

    r_e = s_e + 32'd75;
    push_run(r_e, r_e + 32'd60);
    wait_to(r_e - 32'd1);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("resume_state", 32'(bus.state), 32'd1);

    // lap freeze and release
    bus.time_bcd = 24'h012345;
    wait_to(r_e + 32'd7);
    pulse(1'b0, 1'b1, 1'b0, e);
`ifdef CHRONO_LAP_EN
    chk("lap_state",   32'(bus.state), 32'd3);
    chk("lap_running", 32'(bus.running), 32'd1);
    chk("lap_disp",    32'(bus.disp_bcd), 32'h012345);
    bus.time_bcd = 24'h012399;
    #1;
    chk("lap_disp_hold", 32'(bus.disp_bcd), 32'h012345);
    wait_to(r_e + 32'd30);
    chk("lap_disp_hold_late", 32'(bus.disp_bcd), 32'h012345);
    pulse(1'b0, 1'b1, 1'b0, e);
    chk("lap_exit_state", 32'(bus.state), 32'd1);
    chk("lap_exit_disp",  32'(bus.disp_bcd), 32'h012399);
    bus.time_bcd = 24'h020000;
    #1;
    chk("lap_exit_track", 32'(bus.disp_bcd), 32'h020000);
`else
    chk("lap_off_state", 32'(bus.state), 32'd1);
    chk("lap_off_disp",  32'(bus.disp_bcd), 32'h012345);
    bus.time_bcd = 24'h012399;
    #1;
    chk("lap_off_track", 32'(bus.disp_bcd), 32'h012399);
    wait_to(r_e + 32'd30);
    pulse(1'b0, 1'b1, 1'b0, e);
    chk("lap_off_state2", 32'(bus.state), 32'd1);
`endif

    // simultaneous start+lap+clr in RUN: only start acts
    p_e = r_e + 32'd60;
    bus.time_bcd = 24'h030303;
    wait_to(p_e - 32'd1);
    pulse(1'b1, 1'b1, 1'b1, e);
    chk("multi_state", 32'(bus.state), 32'd2);
    chk("multi_disp",  32'(bus.disp_bcd), 32'h030303);

    // resume, optional lap, then start from LAP/RUN back to PAUSE
    r_e = p_e + 32'd10;
    push_run(r_e, r_e + 32'd22);
    wait_to(r_e - 32'd1);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("resume2_state", 32'(bus.state), 32'd1);
`ifdef CHRONO_LAP_EN
    bus.time_bcd = 24'h111111;
    wait_to(r_e + 32'd2);
    pulse(1'b0, 1'b1, 1'b0, e);
    chk("lap2_state", 32'(bus.state), 32'd3);
`endif
    bus.time_bcd = 24'h111122;
    wait_to(r_e + 32'd21);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("pause2_state", 32'(bus.state), 32'd2);
    chk("pause2_disp",  32'(bus.disp_bcd), 32'h111122);

    // clear from PAUSE with a part-way prescaler, then clear in IDLE
    c_e = r_e + 32'd27;
    exp_clr_q.push_back(c_e);
    wait_to(c_e - 32'd1);
    pulse(1'b0, 1'b0, 1'b1, e);
    chk("clr_state",   32'(bus.state), 32'd0);
    chk("clr_running", 32'(bus.running), 32'd0);
    phase = 0;
    c_e = c_e + 32'd3;
    exp_clr_q.push_back(c_e);
    wait_to(c_e - 32'd1);
    pulse(1'b0, 1'b0, 1'b1, e);
    chk("clr_idle_state", 32'(bus.state), 32'd0);
    wait_to(c_e + 32'd2);
    pulse(1'b0, 1'b1, 1'b0, e);
    chk("lap_in_idle_state", 32'(bus.state), 32'd0);

    // restart, reach prescaler=7, then pulse reset for 1 ns mid-cycle
    s_e = c_e + 32'd10;
    push_run(s_e, s_e + 32'd17);
    wait_to(s_e - 32'd1);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("restart_state", 32'(bus.state), 32'd1);
`ifdef CHRONO_LAP_EN
    bus.time_bcd = 24'h222222;
    wait_to(s_e + 32'd2);
    pulse(1'b0, 1'b1, 1'b0, e);
    chk("lap3_state", 32'(bus.state), 32'd3);
`endif
    bus.time_bcd = 24'h222233;
    wait_to(s_e + 32'd17);
    #1;
    RST = 1'b0;
    #1;
    chk("arst_state",   32'(bus.state), 32'd0);
    chk("arst_running", 32'(bus.running), 32'd0);
    chk("arst_tick",    32'(bus.tick_en), 32'd0);
    chk("arst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
    chk("arst_disp",    32'(bus.disp_bcd), 32'h222233);
    RST = 1'b1;
    phase = 0;
    chk("arst_tick_q_drained", 32'(exp_tick_q.size()), 32'd0);

    // after reset the prescaler restarts from zero
    s_e = edge_cnt + 32'd15;
    push_run(s_e, s_e + 32'd25);
    wait_to(s_e - 32'd1);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("post_rst_state", 32'(bus.state), 32'd1);
    wait_to(s_e + 32'd24);
    pulse(1'b1, 1'b0, 1'b0, e);
    chk("post_rst_pause", 32'(bus.state), 32'd2);
    wait_to(edge_cnt + 32'd5);

    chk("final_tick_q_empty", 32'(exp_tick_q.size()), 32'd0);
    chk("final_clr_q_empty",  32'(exp_clr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chrono_ctrl.md
CHRONO_CTRL -- requirements
Module: chrono_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, counter advance rate in Hz; DIV = CLK_HZ/TICK_HZ (500000 at defaults), DIV >= 2.
REQ-003 CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 start_btn  in  1  debounced one-cycle press pulse, start/stop.
REQ-006 lap_btn  in  1  debounced one-cycle press pulse, lap/split.
REQ-007 clr_btn  in  1  debounced one-cycle press pulse, clear.
REQ-008 time_bcd  in  24  live counter digits, six BCD nibbles; [3:0] is hundredths, [23:20] is minutes tens.
REQ-009 tick_en  out  1  one-cycle counter advance pulse.
REQ-010 cnt_clr  out  1  one-cycle synchronous clear pulse to the counter.
REQ-011 disp_bcd  out  24  digits to the 7-segment decoders.
REQ-012 running  out  1  high in RUN or LAP.
REQ-013 state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.

Function
REQ-014 Transitions SHALL be: IDLE+start -> RUN; RUN+start -> PAUSE; RUN+lap -> LAP; LAP+lap -> RUN; LAP+start -> PAUSE; PAUSE+start -> RUN; PAUSE+clr -> IDLE.
REQ-015 All other button/state combinations SHALL be ignored: lap in IDLE/PAUSE, clr in RUN/LAP.
REQ-016 Simultaneous pulses SHALL be prioritised start > lap > clr; only the highest-priority legal pulse acts.
REQ-017 A clr pulse accepted in IDLE or PAUSE SHALL assert cnt_clr for exactly one cycle, beginning the cycle after acceptance.
REQ-018 Prescaler SHALL count 0..DIV-1 in RUN/LAP, hold in PAUSE, and be 0 in IDLE and after any clear.
REQ-019 tick_en SHALL be high for exactly one cycle each time the prescaler wraps DIV-1 -> 0; never in IDLE/PAUSE.
REQ-020 The first tick_en after IDLE -> RUN SHALL occur exactly DIV cycles after the edge that sampled start_btn.
REQ-021 PAUSE -> RUN SHALL resume from the held prescaler value, so that accumulated run time is exact to one clock.
REQ-022 On entering LAP, time_bcd SHALL be captured into a lap register at the accepting edge; disp_bcd SHALL show that register while in LAP.
REQ-023 Outside LAP, disp_bcd SHALL equal time_bcd combinationally.
REQ-024 In LAP, counting SHALL continue (tick_en keeps pulsing); LAP -> PAUSE SHALL release the display to the live value.
REQ-025 Counter wrap at 59:59.99 belongs to the counter; the controller SHALL keep ticking unchanged.

Reset
REQ-026 While RST is low: state=IDLE, prescaler=0, tick_en=0, cnt_clr=0, lap register=0, running=0, disp_bcd=time_bcd.
REQ-027 Reset assertion mid-operation (any state, any prescaler value) SHALL take effect immediately without waiting for a clock edge.
REQ-028 Button pulses on the first edge after reset release SHALL be honoured normally.

Configuration
REQ-029 Macro CHRONO_LAP_EN defined: LAP state, lap register and display freeze SHALL be built as specified.
REQ-030 Macro CHRONO_LAP_EN undefined: lap_btn SHALL be ignored, LAP SHALL be unreachable, the lap register SHALL be absent, and disp_bcd SHALL always equal time_bcd; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package chrono_pkg SHALL hold the state encodings, BCD_W=24, MAX_TIME=24'h595999 and the default CLK_HZ/TICK_HZ.
REQ-032 The prescaler SHALL be a sub-module chrono_prescaler (enable, hold, clear, tick out), with width $clog2(DIV).

Verification (CLK_HZ=1000, TICK_HZ=100, DIV=10 unless noted)
REQ-033 Reset, then start pulse at edge 0 -> state=1, first tick_en in cycle 10, then every 10 cycles; no other tick_en.
REQ-034 RUN 25 cycles, start pulse (PAUSE), wait 50, start pulse -> tick_en occurs at 10 and 20, none during the pause, next tick 5 cycles after resume.
REQ-035 RUN with time_bcd=24'h012345, lap pulse -> disp_bcd holds 24'h012345 while time_bcd changes and tick_en continues; second lap pulse -> disp_bcd tracks time_bcd.
REQ-036 PAUSE + clr -> cnt_clr high exactly 1 cycle, state=0, prescaler 0; clr in RUN -> no cnt_clr and no state change.
REQ-037 Start, lap and clr pulsed together in RUN -> state=PAUSE, no lap capture, no cnt_clr.
REQ-038 RST low for 1 ns mid-cycle in LAP at prescaler=7 -> all outputs reach reset values asynchronously; with CHRONO_LAP_EN undefined, a lap pulse in RUN leaves state=1.
